// File: rtl/ogfx_vram_arbiter_if.sv
// ogfx_vram_arbiter_if: GFX/HOST requester ports and VRAM macro signals of the VRAM arbiter.
// slave = arbiter side, master = requesters plus RAM side.
interface ogfx_vram_arbiter_if #(
   parameter int AW = 17,
   parameter int DW = 16
);
   logic          gfx_req_i, gfx_we_i, gfx_gnt_o, gfx_rvld_o;
   logic [AW-1:0] gfx_addr_i;
   logic [DW-1:0] gfx_din_i, gfx_dout_o;
   logic          host_req_i, host_we_i, host_gnt_o, host_rvld_o;
   logic [AW-1:0] host_addr_i;
   logic [DW-1:0] host_din_i, host_dout_o;
   logic [AW-1:0] vid_ram_addr_o;
   logic          vid_ram_cen_o, vid_ram_wen_o;
   logic [DW-1:0] vid_ram_din_o, vid_ram_dout_i;
   modport slave (
      input  gfx_req_i, gfx_we_i, gfx_addr_i, gfx_din_i,
      input  host_req_i, host_we_i, host_addr_i, host_din_i, vid_ram_dout_i,
      output gfx_gnt_o, gfx_rvld_o, gfx_dout_o, host_gnt_o, host_rvld_o, host_dout_o,
      output vid_ram_addr_o, vid_ram_cen_o, vid_ram_wen_o, vid_ram_din_o
   );
   modport master (
      output gfx_req_i, gfx_we_i, gfx_addr_i, gfx_din_i,
      output host_req_i, host_we_i, host_addr_i, host_din_i, vid_ram_dout_i,
      input  gfx_gnt_o, gfx_rvld_o, gfx_dout_o, host_gnt_o, host_rvld_o, host_dout_o,
      input  vid_ram_addr_o, vid_ram_cen_o, vid_ram_wen_o, vid_ram_din_o
   );
endinterface

// File: rtl/ogfx_vram_arbiter.sv
// ogfx_vram_arbiter: round-robin sharing of one single-port VRAM between GFX (port 0) and HOST (port 1).
// Define OGFX_VRAM_ARB_BURST_EN to let GFX keep the grant for up to BURST_LEN contended accesses.
module ogfx_vram_arbiter #(
   parameter int AW = 17,
   parameter int DW = 16
`ifdef OGFX_VRAM_ARB_BURST_EN
   , parameter int BURST_LEN = 8
`endif
) (
   input logic                mclk,
   input logic                puc_rst,
   ogfx_vram_arbiter_if.slave bus
);
   logic          gnt_g, gnt_h, we_d, cen_d, wen_d, last_d, last_q, cen_q, wen_q, gfx_pri;
   logic [AW-1:0] addr_d, addr_q;
   logic [DW-1:0] din_d, din_q, gdout_q, hdout_q;
   logic [1:0]    tag1_d, tag1_q, tag2_q;
`ifdef OGFX_VRAM_ARB_BURST_EN
   localparam int CW = $clog2(BURST_LEN + 1);
   logic [CW-1:0] cnt_d, cnt_q;
   // cnt_q counts GFX grants taken while HOST was also requesting
   assign gfx_pri = last_q | (cnt_q < CW'(BURST_LEN));
   assign cnt_d   = gnt_g ? (bus.host_req_i ? cnt_q + CW'(1) : cnt_q) : '0;
   always_ff @(posedge mclk or posedge puc_rst)
      if (puc_rst) cnt_q <= '0;
      else cnt_q <= cnt_d;
`else
   assign gfx_pri = last_q;
`endif
   always_comb begin
      gnt_g  = ~puc_rst & bus.gfx_req_i & (~bus.host_req_i | gfx_pri);
      gnt_h  = ~puc_rst & bus.host_req_i & ~gnt_g;
      we_d   = gnt_g ? bus.gfx_we_i : bus.host_we_i;
      addr_d = gnt_g ? bus.gfx_addr_i : gnt_h ? bus.host_addr_i : addr_q;
      din_d  = gnt_g ? bus.gfx_din_i : gnt_h ? bus.host_din_i : din_q;
      cen_d  = ~(gnt_g | gnt_h);
      wen_d  = cen_d | ~we_d;
      last_d = gnt_g ? 1'b0 : gnt_h ? 1'b1 : last_q;
      tag1_d = {gnt_h & ~bus.host_we_i, gnt_g & ~bus.gfx_we_i};
   end
   always_ff @(posedge mclk or posedge puc_rst)
      if (puc_rst) begin
         addr_q  <= '0;
         din_q   <= '0;
         cen_q   <= 1'b1;
         wen_q   <= 1'b1;
         last_q  <= 1'b1;
         tag1_q  <= '0;
         tag2_q  <= '0;
         gdout_q <= '0;
         hdout_q <= '0;
      end else begin
         addr_q <= addr_d;
         din_q  <= din_d;
         cen_q  <= cen_d;
         wen_q  <= wen_d;
         last_q <= last_d;
         tag1_q <= tag1_d;
         tag2_q <= tag1_q;
         if (tag2_q[0]) gdout_q <= bus.vid_ram_dout_i;
         if (tag2_q[1]) hdout_q <= bus.vid_ram_dout_i;
      end
   // read data is forwarded in the return cycle and held afterwards
   assign bus.gfx_gnt_o      = gnt_g;
   assign bus.host_gnt_o     = gnt_h;
   assign bus.gfx_rvld_o     = tag2_q[0];
   assign bus.host_rvld_o    = tag2_q[1];
   assign bus.gfx_dout_o     = tag2_q[0] ? bus.vid_ram_dout_i : gdout_q;
   assign bus.host_dout_o    = tag2_q[1] ? bus.vid_ram_dout_i : hdout_q;
   assign bus.vid_ram_addr_o = addr_q;
   assign bus.vid_ram_din_o  = din_q;
   assign bus.vid_ram_cen_o  = cen_q;
   assign bus.vid_ram_wen_o  = wen_q;
endmodule

// File: tb/tb_ogfx_vram_arbiter.sv
// tb_ogfx_vram_arbiter: directed bench with a VRAM model and a read-return scoreboard.
// Expected grant patterns follow the build (OGFX_VRAM_ARB_BURST_EN defined or not).
module tb_ogfx_vram_arbiter;
   logic mclk = 1'b0, puc_rst = 1'b1;
   int   vectors = 0, fails = 0, cyc = 0;
   typedef struct {logic p; logic [15:0] d; int due;} exp_t;
   exp_t sb[$];
   logic [15:0] ram [0:(1<<17)-1];
   logic [15:0] shadow [0:(1<<17)-1];
   logic [15:0] rdata = '0;
   ogfx_vram_arbiter_if bus ();
   ogfx_vram_arbiter dut (.mclk(mclk), .puc_rst(puc_rst), .bus(bus));
   always #5 mclk = ~mclk;
   always @(posedge mclk) cyc++;
   always @(posedge mclk)
      if (!bus.vid_ram_cen_o) begin
         if (!bus.vid_ram_wen_o) ram[bus.vid_ram_addr_o] <= bus.vid_ram_din_o;
         else rdata <= ram[bus.vid_ram_addr_o];
      end
   assign bus.vid_ram_dout_i = rdata;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic book(input logic p, input logic we, input logic [16:0] a, input logic [15:0] d);
      if (we) shadow[a] = d;
      else sb.push_back('{p, shadow[a], cyc + 2});
   endtask
   task automatic cycle(input logic r, input logic g, input logic gw, input logic [16:0] ga,
                        input logic [15:0] gd, input logic h, input logic hw,
                        input logic [16:0] ha, input logic [15:0] hd, input logic eg, input logic eh);
      @(posedge mclk);
      #1;
      puc_rst = r;
      bus.gfx_req_i = g; bus.gfx_we_i = gw; bus.gfx_addr_i = ga; bus.gfx_din_i = gd;
      bus.host_req_i = h; bus.host_we_i = hw; bus.host_addr_i = ha; bus.host_din_i = hd;
      @(negedge mclk);
      chk("gfx_gnt", bus.gfx_gnt_o, eg);
      chk("host_gnt", bus.host_gnt_o, eh);
      if (eg) book(1'b0, gw, ga, gd);
      else if (eh) book(1'b1, hw, ha, hd);
   endtask
   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
   endtask
   always @(negedge mclk)
      for (int p = 0; p < 2; p++)
         if (p == 1 ? bus.host_rvld_o : bus.gfx_rvld_o) begin
            vectors++;
            assert (sb.size() > 0) else begin
               fails++;
               $error("FAIL rvld_spurious: observed rvld on port %0d expected none", p);
            end
            if (sb.size() > 0) begin
               exp_t e;
               e = sb.pop_front();
               chk("rvld_port", p, e.p);
               chk("rvld_cycle", cyc, e.due);
               chk("rvld_data", p == 1 ? bus.host_dout_o : bus.gfx_dout_o, e.d);
            end
         end
   initial begin
      logic eg;
      for (int i = 0; i < (1 << 17); i++) begin
         ram[i] = 16'(i) ^ 16'h3C3C;
         shadow[i] = 16'(i) ^ 16'h3C3C;
      end
      {bus.gfx_req_i, bus.gfx_we_i, bus.host_req_i, bus.host_we_i} = '0;
      {bus.gfx_addr_i, bus.gfx_din_i, bus.host_addr_i, bus.host_din_i} = '0;
      // reset held with both ports requesting
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 1'b1, 1'b0, 17'h5, '0, 1'b1, 1'b0, 17'h6, '0, 1'b0, 1'b0);
         chk("rst_cen", bus.vid_ram_cen_o, 1'b1);
         chk("rst_wen", bus.vid_ram_wen_o, 1'b1);
         chk("rst_rvld", {bus.gfx_rvld_o, bus.host_rvld_o}, 2'b00);
         chk("rst_dout", {bus.gfx_dout_o, bus.host_dout_o}, 32'h0);
         chk("rst_addr", bus.vid_ram_addr_o, 17'h0);
      end
      cycle(1'b0, 1'b1, 1'b0, 17'h5, '0, 1'b1, 1'b0, 17'h6, '0, 1'b1, 1'b0);
      // GFX write then read back
      cycle(1'b0, 1'b1, 1'b1, 17'h10, 16'hA5A5, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
      idle(1);
      chk("wr_cen", bus.vid_ram_cen_o, 1'b0);
      chk("wr_wen", bus.vid_ram_wen_o, 1'b0);
      chk("wr_addr", bus.vid_ram_addr_o, 17'h10);
      chk("wr_din", bus.vid_ram_din_o, 16'hA5A5);
      cycle(1'b0, 1'b1, 1'b0, 17'h10, '0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
      idle(1);
      chk("rd_cen", bus.vid_ram_cen_o, 1'b0);
      chk("rd_wen", bus.vid_ram_wen_o, 1'b1);
      idle(2);
      // HOST owns last, then 6 cycles of contention
      cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 17'h20, '0, 1'b0, 1'b1);
      for (int i = 0; i < 6; i++) begin
`ifdef OGFX_VRAM_ARB_BURST_EN
         eg = 1'b1;
`else
         eg = (i % 2) == 0;
`endif
         cycle(1'b0, 1'b1, 1'b0, 17'(32'h100 + i), '0, 1'b1, 1'b0, 17'(32'h200 + i), '0, eg, ~eg);
      end
      idle(2);
      for (int i = 0; i < 4; i++)
         cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 17'(32'h300 + i), '0, 1'b0, 1'b1);
`ifdef OGFX_VRAM_ARB_BURST_EN
      for (int i = 0; i < 20; i++) begin
         eg = (i % 9) < 8;
         cycle(1'b0, 1'b1, 1'b0, 17'(32'h400 + i), '0, 1'b1, 1'b0, 17'(32'h500 + i), '0, eg, ~eg);
      end
`endif
      idle(2);
      // HOST pulses its request for one cycle and loses the tie
      cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 17'h600, '0, 1'b0, 1'b1);
      cycle(1'b0, 1'b1, 1'b0, 17'h610, '0, 1'b1, 1'b0, 17'h620, '0, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 1'b0, 17'h611, '0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
      chk("withdraw_addr", bus.vid_ram_addr_o, 17'h610);
      idle(4);
      // reset while a HOST read is in flight
      cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 17'h700, '0, 1'b0, 1'b1);
      @(posedge mclk);
      #1;
      puc_rst = 1'b1;
      bus.host_req_i = 1'b0;
      sb.delete();
      #1;
      chk("async_cen", bus.vid_ram_cen_o, 1'b1);
      chk("async_rvld", bus.host_rvld_o, 1'b0);
      for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      idle(5);
      chk("sb_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end
endmodule
